reg_file: RTL and testbench

General-purpose register file for the single-cycle MIPS datapath: 32 × 32-bit registers, two combinational read ports feeding the ALU operand inputs (regA/regB path), one synchronous write port driven by the writeback mux. Register $0 is hardwired to zero. A third read-only debug port serves the board display/trace logic. Sits directly upstream of the ALU; writeback data arrives from the ALU result or data-memory path.

---
 rtl/reg_file_pkg.sv | 41 ++++
 rtl/reg_file_read_port.sv | 38 +++
 rtl/reg_file.sv | 94 +++++++++
 tb/tb_reg_file.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types for the single-cycle MIPS datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Also used by the control unit and the writeback mux, so the named register
// indices live here rather than in the register file itself.
package reg_file_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_GP   = 5'd28;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  // Write request as seen by the storage array and the bypass compare.
  // vld is already qualified: a write aimed at $0 never has vld set.
  typedef struct packed {
    logic      vld;
    reg_idx_t  addr;
    reg_data_t dat;
  } wr_req_t;

  // Reset contents of one architectural register. $gp and $sp come up
  // pointing at the data/stack regions; everything else starts at zero.
  function automatic reg_data_t reset_value(input reg_idx_t  idx,
                                            input reg_data_t gp_init,
                                            input reg_data_t sp_init);
    reg_data_t val;
    val = '0;
    if (idx == REG_GP) val = gp_init;
    if (idx == REG_SP) val = sp_init;
    return val;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: 32:1 register mux, $0 zero-check, write bypass.
// Latency: 0 cycles (pure combinational from address, storage and write request).
// Backpressure: none; a read is always served in the cycle it is presented.
//
// Ports:
//   regs    - storage for $1..$31 (no slot for $0)
//   rd_addr - register index to read
//   byp_en  - allow the in-flight write to be forwarded to this port
//   wr      - in-flight write request (qualified, never targets $0)
//   rd_dat  - read result
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  logic [NUM_REGS-1:1][DATA_W-1:0] regs,
  input  reg_idx_t                        rd_addr,
  input  logic                            byp_en,
  input  wr_req_t                         wr,
  output reg_data_t                       rd_dat
);

  logic byp_hit;

  // wr.vld already excludes $0, so a hit can never override the zero-check;
  // the explicit $0 test below still comes first to make that unconditional.
  assign byp_hit = byp_en && wr.vld && (wr.addr == rd_addr);

  always_comb begin
    rd_dat = '0;
    if (rd_addr == REG_ZERO) begin
      rd_dat = '0;
    end else if (byp_hit) begin
      rd_dat = wr.dat;
    end else begin
      rd_dat = regs[rd_addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two operand read ports, one write port, one debug port.
// Latency: reads 0 cycles; writes land on the next rising CLK (optionally forwarded same cycle).
// Backpressure: none; one read per port and one write accepted every cycle.
//
// Ports:
//   CLK, Reset            - clock, synchronous active-high reset
//   rs / readDataA        - ALU A-operand read port
//   rt / readDataB        - ALU B-operand / store-data read port
//   regWrite, writeReg,
//   writeData             - writeback port
//   dbgAddr / dbgData     - display/trace read port, never forwarded
module reg_file
  import reg_file_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [REG_IDX_W-1:0] rt,
  output logic [DATA_W-1:0]    readDataA,
  output logic [DATA_W-1:0]    readDataB,
  input  logic                 regWrite,
  input  logic [REG_IDX_W-1:0] writeReg,
  input  logic [DATA_W-1:0]    writeData,
  input  logic [REG_IDX_W-1:0] dbgAddr,
  output logic [DATA_W-1:0]    dbgData
);

  // $0 has no storage; index 0 of the array simply does not exist.
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_W-1:0] regs_d;

  wr_req_t wr_req;
  logic    byp_en;

  // Writes to $0 are dropped here so neither storage nor bypass ever sees them.
  always_comb begin
    wr_req      = '0;
    wr_req.vld  = regWrite && (writeReg != REG_ZERO);
    wr_req.addr = writeReg;
    wr_req.dat  = writeData;
  end

  // Forwarding is switched off during reset: the pending write is about to be
  // discarded, so showing it on the read ports would be misleading.
  assign byp_en = BYPASS && !Reset;

  always_comb begin
    regs_d = regs_q;
    if (wr_req.vld) begin
      regs_d[wr_req.addr] = wr_req.dat;
    end
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= reset_value(reg_idx_t'(i), GP_INIT, SP_INIT);
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_read_port u_port_a (
    .regs    (regs_q),
    .rd_addr (rs),
    .byp_en  (byp_en),
    .wr      (wr_req),
    .rd_dat  (readDataA)
  );

  reg_file_read_port u_port_b (
    .regs    (regs_q),
    .rd_addr (rt),
    .byp_en  (byp_en),
    .wr      (wr_req),
    .rd_dat  (readDataB)
  );

  // Debug view always shows committed storage.
  reg_file_read_port u_port_dbg (
    .regs    (regs_q),
    .rd_addr (dbgAddr),
    .byp_en  (1'b0),
    .wr      ('0),
    .rd_dat  (dbgData)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed plus scoreboard-checked stimulus for reg_file, run on a forwarding
// and a non-forwarding instance that share the same inputs.
module tb_reg_file;

  logic        CLK;
  logic        Reset;
  logic [4:0]  rs, rt, writeReg, dbgAddr;
  logic        regWrite;
  logic [31:0] writeData;
  logic [31:0] a1, b1, d1;
  logic [31:0] a0, b0, d0;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] SP_RST = 32'h0000_0FFC;
  localparam logic [31:0] GP_RST = 32'h0000_1800;

  logic [31:0] sb [32];

  reg_file #(.SP_INIT(SP_RST), .GP_INIT(GP_RST), .BYPASS(1'b1)) u_dut_byp (
    .CLK(CLK), .Reset(Reset), .rs(rs), .rt(rt),
    .readDataA(a1), .readDataB(b1),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .dbgAddr(dbgAddr), .dbgData(d1)
  );

  reg_file #(.SP_INIT(SP_RST), .GP_INIT(GP_RST), .BYPASS(1'b0)) u_dut_nob (
    .CLK(CLK), .Reset(Reset), .rs(rs), .rt(rt),
    .readDataA(a0), .readDataB(b0),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .dbgAddr(dbgAddr), .dbgData(d0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rst_val(input int i);
    if (i == 28) return GP_RST;
    if (i == 29) return SP_RST;
    return 32'h0;
  endfunction

  initial begin
    logic [31:0] exp_a1, exp_b1;

    Reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    rs = '0; rt = '0; dbgAddr = '0;

    // Reset: one edge, then walk the debug port over every register.
    tick();
    Reset = 1'b0;
    #1;
    check("rst_a_byp", a1, 32'h0);
    check("rst_b_byp", b1, 32'h0);
    check("rst_dbg0_byp", d1, 32'h0);
    check("rst_a_nob", a0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbgAddr = 5'(i);
      #1;
      check($sformatf("rst_dbg%0d_byp", i), d1, rst_val(i));
      check($sformatf("rst_dbg%0d_nob", i), d0, rst_val(i));
    end
    rs = 5'd29; rt = 5'd28;
    #1;
    check("rst_sp_port_a", a1, SP_RST);
    check("rst_gp_port_b", b1, GP_RST);

    // Plain write then read on the next cycle.
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
    rs = 5'd1; rt = 5'd1;
    tick();
    regWrite = 1'b0; rs = 5'd5; rt = 5'd5;
    #1;
    check("wr5_a_byp", a1, 32'hDEAD_BEEF);
    check("wr5_b_byp", b1, 32'hDEAD_BEEF);
    check("wr5_a_nob", a0, 32'hDEAD_BEEF);
    check("wr5_b_nob", b0, 32'hDEAD_BEEF);
    rs = 5'd6;
    #1;
    check("rd6_a_byp", a1, 32'h0);
    check("rd6_a_nob", a0, 32'h0);

    // $0 stays zero even while being written and forwarded.
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
    rs = 5'd0; rt = 5'd0; dbgAddr = 5'd0;
    #1;
    check("z0_same_a_byp", a1, 32'h0);
    check("z0_same_b_byp", b1, 32'h0);
    check("z0_same_a_nob", a0, 32'h0);
    tick();
    regWrite = 1'b0;
    #1;
    check("z0_after_a_byp", a1, 32'h0);
    check("z0_after_dbg_byp", d1, 32'h0);
    check("z0_after_dbg_nob", d0, 32'h0);

    // Forwarding: $7 = 1111_1111, then overwrite with 2222_2222 while reading it.
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h1111_1111;
    tick();
    writeData = 32'h2222_2222; rs = 5'd7; rt = 5'd7; dbgAddr = 5'd7;
    #1;
    check("byp_a_fwd", a1, 32'h2222_2222);
    check("byp_b_fwd", b1, 32'h2222_2222);
    check("byp_dbg_fwd", d1, 32'h1111_1111);
    check("nob_a_old", a0, 32'h1111_1111);
    check("nob_b_old", b0, 32'h1111_1111);
    check("nob_dbg_old", d0, 32'h1111_1111);
    tick();
    regWrite = 1'b0;
    #1;
    check("byp_a_post", a1, 32'h2222_2222);
    check("nob_a_post", a0, 32'h2222_2222);
    check("nob_dbg_post", d0, 32'h2222_2222);

    // Reset beats a simultaneous write; forwarding is muted during reset.
    Reset = 1'b1; regWrite = 1'b1; writeReg = 5'd29; writeData = 32'h1234_5678;
    rs = 5'd29; rt = 5'd7; dbgAddr = 5'd29;
    #1;
    check("rstwr_a_nofwd", a1, SP_RST);
    check("rstwr_b_preval", b1, 32'h2222_2222);
    tick();
    Reset = 1'b0; regWrite = 1'b0;
    #1;
    check("rstwr_sp_byp", d1, SP_RST);
    check("rstwr_sp_nob", d0, SP_RST);
    check("rstwr_r7_clr", b1, 32'h0);
    rs = 5'd5;
    #1;
    check("rstwr_r5_clr", a1, 32'h0);

    // Scoreboard-checked random traffic with forced collisions and $0 writes.
    for (int i = 0; i < 32; i++) sb[i] = rst_val(i);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      Reset     = ($urandom_range(63) == 0);
      regWrite  = $urandom_range(1);
      writeReg  = 5'($urandom_range(31));
      writeData = $urandom;
      rs        = 5'($urandom_range(31));
      rt        = 5'($urandom_range(31));
      dbgAddr   = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) begin
        rt = rs;
        writeReg = rs;
      end
      if ($urandom_range(7) == 0) writeReg = 5'd0;
      #1;
      exp_a1 = sb[rs];
      exp_b1 = sb[rt];
      if (!Reset && regWrite && writeReg != 0) begin
        if (writeReg == rs) exp_a1 = writeData;
        if (writeReg == rt) exp_b1 = writeData;
      end
      if (rs == 0) exp_a1 = 32'h0;
      if (rt == 0) exp_b1 = 32'h0;
      check("rnd_a_byp", a1, exp_a1);
      check("rnd_b_byp", b1, exp_b1);
      check("rnd_dbg_byp", d1, (dbgAddr == 0) ? 32'h0 : sb[dbgAddr]);
      check("rnd_a_nob", a0, (rs == 0) ? 32'h0 : sb[rs]);
      check("rnd_b_nob", b0, (rt == 0) ? 32'h0 : sb[rt]);
      check("rnd_dbg_nob", d0, (dbgAddr == 0) ? 32'h0 : sb[dbgAddr]);
      if (Reset) begin
        for (int i = 0; i < 32; i++) sb[i] = rst_val(i);
      end else if (regWrite && writeReg != 0) begin
        sb[writeReg] = writeData;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
